// File: rtl/regfile_pkg.sv
// Shared definitions for the ID-stage register file with pending-write scoreboard.
// Holds the default geometry (data width, register count, read-port count),
// the address-width helper and an address typedef for the default geometry.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 15;
    localparam int DEF_NUM_RD   = 2;

    // One spare code beyond the last register so that an "out of range"
    // address (e.g. R15/PC, which lives outside this file) is representable.
    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs + 1);
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard for the register file.
// One pending bit per register: set when an instruction targeting the register
// issues, cleared when its writeback lands. A same-cycle issue wins over a
// writeback because the issuing instruction is the younger producer.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   iss_en/iss_addr   destination of the instruction issuing this cycle
//   wb_en/wb_addr     register being written back this cycle
//   pending           current pending vector (registered)
//   any_pending       OR of all pending bits
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] pending,
    output logic                any_pending
);

    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;

    // Out-of-range addresses never match any register index, so they leave
    // the vector untouched without needing a separate range check.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign pending_next[gi] =
                (iss_en && (iss_addr == ADDR_W'(gi))) ? 1'b1 :
                (wb_en  && (wb_addr  == ADDR_W'(gi))) ? 1'b0 :
                                                        pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending     = pending_reg;
    assign any_pending = |pending_reg;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback bypass and per-register
// pending-write scoreboard, used by the ID stage and its hazard unit.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   rd_addr/rd_data      NUM_RD packed read ports, combinational, with bypass
//   rd_pending           per-port pending flag of the addressed register
//   wb_en/wb_addr/wb_data writeback port
//   iss_en/iss_addr      destination of the instruction issuing this cycle
//   any_pending          any register still awaiting its writeback
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_pending
);

    localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);
    localparam int                ADDR_SPAN = 2 ** ADDR_W;

    // Reset loads each register with its own index, so the array is kept in
    // flops rather than block RAM.
    logic [DATA_W-1:0]    rf_reg [NUM_REGS];
    logic [NUM_REGS-1:0]  pending;
    logic [ADDR_SPAN-1:0] pending_ext;
    logic                 wb_valid;

    assign wb_valid = wb_en && (wb_addr < REG_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= DATA_W'(i);
            end
        end else if (wb_valid) begin
            rf_reg[wb_addr] <= wb_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .pending     (pending),
        .any_pending (any_pending)
    );

    // Widened so that every address code indexes a real bit.
    assign pending_ext = {{(ADDR_SPAN - NUM_REGS){1'b0}}, pending};

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            logic              wb_hit;

            assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
            assign in_range = addr < REG_LIMIT;
            // While reset is held the outputs must show the reset contents,
            // so a writeback presented during reset is not forwarded.
            assign wb_hit   = rst && wb_en && (wb_addr == addr);

            assign rd_data[gi*DATA_W +: DATA_W] =
                !in_range ? '0 :
                wb_hit    ? wb_data :
                            rf_reg[addr];

            // The completing writeback is already visible via the bypass,
            // so it must not stall the consumer.
            assign rd_pending[gi] = in_range && pending_ext[addr] && !wb_hit;
        end
    endgenerate

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a built-in pending-write scoreboard. It replaces the fixed 15×32, two-read-port register file in the ID stage. Writeback data bypasses to the read ports in the same cycle. Each register carries a pending bit, set when an instruction that targets it issues and cleared at its writeback, so the hazard unit can stall on any port without a separate hazard table.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 15, number of architectural registers (R0..R14; R15/PC lives outside)
- NUM_RD, 2, number of read ports
- ADDR_W, $clog2(NUM_REGS+1), address width; covers one out-of-range code

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_pending  out  NUM_RD  per-port pending flag of the addressed register, combinational
- wb_en  in  1  writeback enable
- wb_addr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- iss_en  in  1  an instruction with a register destination issues this cycle
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- any_pending  out  1  OR of all pending bits (drain/flush indicator)

## Operation
- Storage:
  - NUM_REGS × DATA_W array.
  - The array plus a NUM_REGS-bit pending vector is the only state.
- Write: on a rising clk with wb_en=1 and wb_addr<NUM_REGS, RF[wb_addr] ← wb_data.
- Read, port k:
  - if rd_addr_k ≥ NUM_REGS: data = 0, pending = 0.
  - else if wb_en and wb_addr==rd_addr_k: data = wb_data (bypass).
  - else: data = RF[rd_addr_k].
- Pending update on a rising clk, per register r:
  - set if iss_en and iss_addr==r;
  - else clear if wb_en and wb_addr==r;
  - else hold.
  - Simultaneous issue and writeback to the same r leaves the bit set, because the new producer is younger.
- rd_pending_k:
  - pending[rd_addr_k] AND NOT (wb_en and wb_addr==rd_addr_k).
  - The writeback that completes the register this cycle is visible through the bypass, so it does not stall.
  - A same-cycle issue to the same register is not reflected until the next cycle.
- Out-of-range wb_addr or iss_addr: no state change.
- Reset (rst=0, asynchronous):
  - RF[i] ← i, zero-extended to DATA_W.
  - All pending bits ← 0.
  - Reset mid-operation discards in-flight state immediately; outputs follow the reset contents combinationally.

## Timing
- Read latency 0 (combinational from rd_addr, RF, and the wb_* inputs).
- Write latency 1: a value written at edge N is read from the array from cycle N+1 onward; in cycle N it comes from the bypass.
- Pending set at edge N is visible on rd_pending from cycle N+1.
- No handshake; the issuing stage guarantees at most one issue per cycle.
- Outputs during reset: rd_data = per-address reset value, rd_pending = 0, any_pending = 0.

## Structure
- Package regfile_pkg: default DATA_W/NUM_REGS/NUM_RD constants, the ADDR_W helper function, and a reg_addr_t typedef.
- Sub-module rf_scoreboard:
  - holds the pending vector, set/clear priority, and any_pending;
  - parametrised by NUM_REGS and ADDR_W.
- The top level holds the storage array, the write logic, and a generate loop for the NUM_RD read ports with bypass and pending masking.

## Test plan
- Reset, then read R0..R14 on both ports: rd_data = 0..14, all rd_pending = 0, any_pending = 0. Read address 15: rd_data = 0.
- Write R3 ← 0xDEADBEEF with rd_addr0 = 3 in the same cycle: rd_data0 = 0xDEADBEEF in that cycle (bypass) and in the next (array).
- iss_en, iss_addr = 5 at edge N: rd_pending for address 5 = 1 from N+1. With wb_en, wb_addr = 5 in cycle M: rd_pending = 0 in M, pending bit cleared after edge M.
- Same cycle iss_addr = 7 and wb_addr = 7 while pending[7] = 1: after the edge, pending[7] = 1 and RF[7] = wb_data.
- Issue R2 and R9, then pull rst low asynchronously mid-cycle: any_pending drops immediately, RF[2] = 2, RF[9] = 9.
- Out-of-range wb_addr = 15 and iss_addr = 15: no register changes, any_pending unchanged. Repeat with NUM_RD = 4 and DATA_W = 64, with all ports reading distinct registers.
